findmax_ctrl: RTL and testbench
===============================

# findmax_ctrl

Sequencing controller for the findMax datapath. It accepts a run of N unsigned samples over a valid/ready stream. It drives the load enable of the max-holding register from the datapath comparator result. It signals completion when the register holds the run's maximum. The controller sits between the stream source and the datapath (max register plus `D > Q` comparator), which stays outside this block.

## Interface
Parameters:
- `N`, default 16: samples per run; legal range N >= 1.
- `IDXW`, default `$clog2(N)` (minimum 1): width of the sample index and `max_idx`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: rst, asynchronous, active-high; clock clk.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  synchronous abandon of the current run.
- `in_valid`  in  1  source has a sample on the datapath D bus.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `gt`  in  1  datapath comparator: current D strictly greater than register Q (unsigned).
- `ld_en`  out  1  enable to the max register; Q <= D at this edge.
- `busy`  out  1  run in progress (FIRST or RUN).
- `done`  out  1  one-cycle pulse; Q holds the run maximum.
- `max_idx`  out  IDXW  index of the maximum sample; present only with FINDMAX_IDX_EN.

## Operation
- Accept = `in_valid && in_ready`. A sample is consumed only on accept.
- State machine has four states: IDLE, FIRST, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 moves to FIRST.
- FIRST:
  - `in_ready`=1.
  - On accept, `ld_en`=1 unconditionally, so the first sample overwrites any stale Q and no register clear is needed.
  - On accept, cnt <= 1 and idx <= 0.
  - Next state is DONE if N==1, else RUN.
- RUN:
  - `in_ready`=1.
  - On accept, `ld_en` = `gt` and cnt <= cnt+1.
  - If `gt`, idx <= cnt, which is the index of the current sample.
  - If cnt == N-1 at accept, the next state is DONE.
- DONE:
  - `done`=1 and `in_ready`=0.
  - Next state is IDLE unconditionally.
- `ld_en` is combinational from state, `in_valid` and `gt`. It is never high without an accept.
- Ties keep the earliest index, because `gt` is strict.
- `abort`:
  - In FIRST or RUN it returns the FSM to IDLE next cycle. No `done` is produced.
  - `ld_en` is forced 0 in the abort cycle.
  - Q content afterwards is don't-care.
  - `abort` has no effect in IDLE or DONE.
- `start` outside IDLE is ignored. It is not queued.
- `abort` and `start` both high in IDLE: `start` wins.
- Counter width is `$clog2(N+1)`. It never wraps, because the run ends at N.

## Timing
- Reset values: state=IDLE; `in_ready`=0, `ld_en`=0, `busy`=0, `done`=0; cnt=0; `max_idx`=0.
- Reset mid-run returns to IDLE immediately. The external register shares `rst`, so Q=0.
- Continuous valid:
  - `start` sampled at edge 0.
  - Samples are accepted in cycles 1..N.
  - `done` is high in cycle N+1 and `busy` is low in cycle N+1.
  - Q is final from cycle N+1.
- Valid gaps stretch the run one cycle per idle cycle. `done` follows the Nth accept by exactly one cycle.
- `max_idx` updates at the accepting edge and is stable while in IDLE/DONE.
- Minimum start-to-start spacing: N+2 cycles.

## Configuration
- `FINDMAX_IDX_EN` defined:
  - The idx register and `max_idx` port exist.
  - `max_idx` gives the index (0..N-1) of the first occurrence of the maximum, valid from `done` until the next accepted first sample.
- `FINDMAX_IDX_EN` undefined:
  - The port and register are absent.
  - All other behaviour is identical, cycle for cycle.

## Test plan
- N=4, samples 3,9,2,9 with continuous valid:
  - `ld_en` is high on samples 0 and 1 only.
  - Q=9, `max_idx`=1.
  - `done` is high in cycle 5, one cycle wide.
- N=4, samples 5,1,1,1, then a second run 2,7,7,3:
  - First run: Q=5, `max_idx`=0.
  - Second run: the first sample loads despite 2<5; Q=7, `max_idx`=1.
- N=4, valid deasserted for 3 cycles after sample 1:
  - No `ld_en` or count change during the gap.
  - `done` comes 1 cycle after the 4th accept.
- N=1, sample 0xAA:
  - `ld_en` high for 1 cycle.
  - `done` in cycle 2.
  - `max_idx`=0.
- Runtime control, N=8:
  - `start` pulsed while busy is ignored and `done` timing is unchanged.
  - `abort` after 3 samples gives IDLE next cycle, no `done`, and `in_ready`=0.
- Reset mid-run, N=8:
  - Assert `rst` after 5 samples; all outputs go to reset values asynchronously.
  - Following a new `start`, a full run completes correctly.

Source files
------------

// File: rtl/findmax_ctrl.sv
// findmax_ctrl: sequencing controller for the findMax datapath.
//
// Accepts a run of N unsigned samples over a valid/ready stream. It drives
// the load enable of the external max register (Q) from the external
// comparator result (gt = D > Q, strict, unsigned). It pulses done for one
// cycle once Q holds the maximum of the run.
//
// Ports:
//   clk       clock
//   rst       asynchronous, active-high reset
//   start     begin a run (sampled only in IDLE)
//   abort     synchronous abandon of the current run (FIRST/RUN only)
//   in_valid  source presents a sample on the datapath D bus
//   in_ready  controller accepts a sample this cycle
//   gt        datapath comparator: D > Q
//   ld_en     max register load enable (Q <= D at this edge)
//   busy      run in progress
//   done      one-cycle pulse, Q holds the run maximum
//   max_idx   index of the first occurrence of the maximum
//             (present only when FINDMAX_IDX_EN is defined)
//
// Build option: define FINDMAX_IDX_EN to add the index register and max_idx.

module findmax_ctrl #(
  parameter int N    = 16,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            gt,
  output logic            ld_en,
  output logic            busy,
  output logic            done
`ifdef FINDMAX_IDX_EN
  ,
  output logic [IDXW-1:0] max_idx
`endif
);

  localparam int CNTW = $clog2(N + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CNTW-1:0] cnt;
  logic            accept;

  // An abort cycle consumes nothing: no load, no count, no index update.
  assign accept = in_valid && in_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = FIRST;
      end
      FIRST: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (accept) begin
          state_nx = (N == 1) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (accept && (cnt == LAST)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ld_en    = 1'b0;
    unique case (state)
      FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // First sample always loads so stale Q never needs clearing.
        ld_en    = in_valid && !abort;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        ld_en    = in_valid && !abort && gt;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      if (state == FIRST) begin
        cnt <= CNTW'(1);
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

`ifdef FINDMAX_IDX_EN
  // cnt equals the index of the sample being accepted in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx <= '0;
    end else if (accept) begin
      if (state == FIRST) begin
        max_idx <= '0;
      end else if (gt) begin
        max_idx <= IDXW'(cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_findmax_ctrl.sv
// Testbench for findmax_ctrl: three instances (N=4, N=1, N=8), each with a
// behavioural model of the external max register and comparator. Expected
// load pattern, maximum, index and done timing come from a running-maximum
// model computed over the sample list.

module tb_findmax_ctrl;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       start = '0;
  logic [2:0]       abort = '0;
  logic [2:0]       in_valid = '0;
  logic [2:0][7:0]  d = '0;
  logic [2:0]       in_ready;
  logic [2:0]       ld_en;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][7:0]  q_all;
  logic [2:0][7:0]  midx_all;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NN = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    logic          rdy_l, ld_l, busy_l, done_l, gt_l;
    logic [7:0]    q;
    logic [IW-1:0] mi;

    findmax_ctrl #(.N(NN)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start[g]),
      .abort   (abort[g]),
      .in_valid(in_valid[g]),
      .in_ready(rdy_l),
      .gt      (gt_l),
      .ld_en   (ld_l),
      .busy    (busy_l),
      .done    (done_l)
`ifdef FINDMAX_IDX_EN
      ,
      .max_idx (mi)
`endif
    );

`ifndef FINDMAX_IDX_EN
    assign mi = '0;
`endif

    // External datapath: max register and strict unsigned comparator.
    assign gt_l = d[g] > q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else if (ld_l) q <= d[g];
    end

    assign in_ready[g] = rdy_l;
    assign ld_en[g]    = ld_l;
    assign busy[g]     = busy_l;
    assign done[g]     = done_l;
    assign q_all[g]    = q;
    assign midx_all[g] = 8'(mi);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on instance k. gap_at/gap_len: hold valid low for gap_len cycles
  // before sample gap_at. rnd: random valid gaps. poke: pulse start mid-run.
  task automatic run(input int k, input int n, input logic [7:0] s[$],
                     input int gap_at, input int gap_len, input bit rnd,
                     input bit poke);
    int         i = 0;
    int         cyc = 0;
    int         gaps = 0;
    int         gapleft = gap_len;
    int         mi = 0;
    logic [7:0] mx = '0;
    bit         v;
    bit         exp_ld;
    start[k] = 1'b1;
    #1;
    chk("idle_ready", in_ready[k], 0);
    chk("idle_busy", busy[k], 0);
    tick();
    start[k] = 1'b0;
    while (i < n && cyc < 200) begin
      cyc++;
      if (gapleft > 0 && i == gap_at) begin
        v = 1'b0;
        gapleft--;
      end else if (rnd) begin
        v = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b1;
      end
      if (!v) gaps++;
      in_valid[k] = v;
      d[k]        = v ? s[i] : 8'($urandom);
      start[k]    = poke && (cyc == 2);
      #1;
      exp_ld = v && (i == 0 || s[i] > mx);
      chk("run_ready", in_ready[k], 1);
      chk("run_busy", busy[k], 1);
      chk("run_done_early", done[k], 0);
      chk("ld_en", ld_en[k], exp_ld);
      if (v) begin
        if (exp_ld) begin
          mx = s[i];
          mi = i;
        end
        i++;
      end
      tick();
    end
    chk("run_complete", i, n);
    chk("run_length", cyc, n + gaps);
    in_valid[k] = 1'b0;
    start[k]    = 1'b0;
    #1;
    chk("done", done[k], 1);
    chk("done_busy", busy[k], 0);
    chk("done_ready", in_ready[k], 0);
    chk("done_ld", ld_en[k], 0);
    chk("max_value", q_all[k], mx);
`ifdef FINDMAX_IDX_EN
    chk("max_idx", midx_all[k], mi);
`endif
    tick();
    chk("done_width", done[k], 0);
    chk("after_busy", busy[k], 0);
`ifdef FINDMAX_IDX_EN
    chk("max_idx_hold", midx_all[k], mi);
`endif
  endtask

  initial begin
    logic [7:0] smp[$];

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", in_ready[k], 0);
      chk("rst_ld", ld_en[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_idx", midx_all[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // N=4: 3,9,2,9 continuous
    smp = '{8'd3, 8'd9, 8'd2, 8'd9};
    run(0, 4, smp, -1, 0, 1'b0, 1'b0);
    // N=4: back-to-back runs, second first sample loads despite being smaller
    smp = '{8'd5, 8'd1, 8'd1, 8'd1};
    run(0, 4, smp, -1, 0, 1'b0, 1'b0);
    smp = '{8'd2, 8'd7, 8'd7, 8'd3};
    run(0, 4, smp, -1, 0, 1'b0, 1'b0);
    // N=4: 3-cycle valid gap after sample 1
    smp = '{8'd4, 8'd6, 8'd1, 8'd8};
    run(0, 4, smp, 2, 3, 1'b0, 1'b0);
    // N=1: single sample
    smp = '{8'hAA};
    run(1, 1, smp, -1, 0, 1'b0, 1'b0);
    // N=8: start pulsed while busy is ignored
    smp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run(2, 8, smp, -1, 0, 1'b0, 1'b1);

    // N=8: abort after 3 samples
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid[2] = 1'b1;
      d[2] = 8'(10 + j);
      tick();
    end
    d[2]     = 8'hFF;
    abort[2] = 1'b1;
    #1;
    chk("abort_ld", ld_en[2], 0);
    chk("abort_busy_cycle", busy[2], 1);
    tick();
    abort[2]    = 1'b0;
    in_valid[2] = 1'b0;
    #1;
    chk("abort_busy", busy[2], 0);
    chk("abort_ready", in_ready[2], 0);
    for (int j = 0; j < 10; j++) begin
      chk("abort_no_done", done[2], 0);
      tick();
    end
    // start and abort together in IDLE: start wins
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    abort[2] = 1'b0;
    #1;
    chk("start_wins", busy[2], 1);
    abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0;
    chk("abort_first", busy[2], 0);
    abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0;
    chk("abort_idle", busy[2], 0);

    // N=8: reset mid-run after 5 samples
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid[2] = 1'b1;
      d[2] = 8'($urandom_range(1, 255));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ready", in_ready[2], 0);
    chk("mrst_ld", ld_en[2], 0);
    chk("mrst_busy", busy[2], 0);
    chk("mrst_done", done[2], 0);
    chk("mrst_q", q_all[2], 0);
    chk("mrst_idx", midx_all[2], 0);
    in_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    smp = '{8'd9, 8'd3, 8'd9, 8'd200, 8'd0, 8'd200, 8'd17, 8'd1};
    run(2, 8, smp, -1, 0, 1'b0, 1'b0);

    // Randomized runs with random valid gaps (narrow value range forces ties)
    for (int r = 0; r < 12; r++) begin
      int k;
      int n;
      k = (r % 3);
      n = (k == 0) ? 4 : (k == 1) ? 1 : 8;
      smp = {};
      for (int j = 0; j < n; j++) smp.push_back(8'($urandom_range(0, 15)));
      run(k, n, smp, -1, 0, 1'b1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
